// File: rtl/mmc1_serial_mapper.sv
// mmc1_serial_mapper
// MMC1-class bank controller. The CPU programs five internal registers through
// a 5-write serial port at $8000-$FFFF. The controller then produces the PRG,
// CHR and nametable (CIRAM) bank lines combinationally from that state.
//
// Ports:
//   CPU_M2            clock; all state updates on its falling edge
//   RST               asynchronous active-high reset
//   nCPU_ROMSEL       low = $8000-$FFFF access
//   nCPU_RW           low = write
//   CPU_A13/CPU_A14   register select, PRG half select
//   CPU_D0/CPU_D7     serial data bit / shift reset
//   PPU_A10..A12      live PPU address bits
//   CIRAM_A10         nametable select
//   PRG_A             PRG A14 and up (outer bit on top when OUTER_PRG=1)
//   CHR_A             CHR A12 and up
//   nPRG_CE           PRG ROM enable (CPU reads of $8000-$FFFF)
//   nWRAM_CE          WRAM enable ($6000-$7FFF, unless disabled by prg[4])
//   SHIFT_CNT         serial bits accepted so far (0..4)
module mmc1_serial_mapper #(
  parameter int PRG_BANK_W = 4,
  parameter int CHR_BANK_W = 5,
  parameter int OUTER_PRG  = 0,
  parameter int WR_FILTER  = 1
) (
  input  logic                            CPU_M2,
  input  logic                            RST,
  input  logic                            nCPU_ROMSEL,
  input  logic                            nCPU_RW,
  input  logic                            CPU_A13,
  input  logic                            CPU_A14,
  input  logic                            CPU_D0,
  input  logic                            CPU_D7,
  input  logic                            PPU_A10,
  input  logic                            PPU_A11,
  input  logic                            PPU_A12,
  output logic                            CIRAM_A10,
  output logic [PRG_BANK_W+OUTER_PRG-1:0] PRG_A,
  output logic [CHR_BANK_W-1:0]           CHR_A,
  output logic                            nPRG_CE,
  output logic                            nWRAM_CE,
  output logic [2:0]                      SHIFT_CNT
);

  logic [4:0] ctrl, chr0, chr1, prg;
  logic [3:0] shift;
  logic [2:0] cnt;
  logic       prev_wr;

  logic       rom_wr, accept;
  logic [4:0] value, sel;
  logic [PRG_BANK_W-1:0] prg_split, prg_inner;
  logic       unused_bits;

  assign rom_wr = !nCPU_ROMSEL && !nCPU_RW;
  // A read-modify-write instruction produces two ROM writes on adjacent
  // cycles; only the first one is meant for the mapper.
  assign accept = rom_wr && !((WR_FILTER != 0) && prev_wr);
  assign value  = {CPU_D0, shift};

  always_ff @(negedge CPU_M2 or posedge RST) begin
    if (RST) begin
      ctrl    <= 5'b01100;
      chr0    <= '0;
      chr1    <= '0;
      prg     <= '0;
      shift   <= '0;
      cnt     <= '0;
      prev_wr <= 1'b0;
    end else begin
      prev_wr <= rom_wr;
      if (accept) begin
        if (CPU_D7) begin
          cnt   <= '0;
          shift <= '0;
          ctrl  <= ctrl | 5'b01100;
        end else if (cnt != 3'd4) begin
          shift[cnt[1:0]] <= CPU_D0;
          cnt             <= cnt + 3'd1;
        end else begin
          case ({CPU_A14, CPU_A13})
            2'b00:   ctrl <= value;
            2'b01:   chr0 <= value;
            2'b10:   chr1 <= value;
            default: prg  <= value;
          endcase
          cnt <= '0;
        end
      end
    end
  end

  assign SHIFT_CNT = cnt;

  // Mirroring
  always_comb begin
    CIRAM_A10 = 1'b0;
    case (ctrl[1:0])
      2'b00:   CIRAM_A10 = 1'b0;
      2'b01:   CIRAM_A10 = 1'b1;
      2'b10:   CIRAM_A10 = PPU_A10;
      default: CIRAM_A10 = PPU_A11;
    endcase
  end

  // Selected CHR register; in 8 KB mode chr0 always drives.
  assign sel = (ctrl[4] && PPU_A12) ? chr1 : chr0;

  // A one-bit bank field has no upper bits to keep in the paired modes.
  if (CHR_BANK_W == 1) begin : g_chr_one
    assign CHR_A = ctrl[4] ? sel[0] : PPU_A12;
  end else begin : g_chr_multi
    assign CHR_A = ctrl[4] ? sel[CHR_BANK_W-1:0]
                           : {chr0[CHR_BANK_W-1:1], PPU_A12};
  end

  if (PRG_BANK_W == 1) begin : g_prg_one
    assign prg_split = CPU_A14;
  end else begin : g_prg_multi
    assign prg_split = {prg[PRG_BANK_W-1:1], CPU_A14};
  end

  always_comb begin
    prg_inner = prg_split;
    case (ctrl[3:2])
      2'b10:   prg_inner = CPU_A14 ? prg[PRG_BANK_W-1:0] : '0;
      2'b11:   prg_inner = CPU_A14 ? '1 : prg[PRG_BANK_W-1:0];
      default: prg_inner = prg_split;
    endcase
  end

  // SUROM boards route bit 4 of the active CHR register to the PRG 256 KB
  // half select, regardless of PRG mode.
  if (OUTER_PRG != 0) begin : g_outer
    assign PRG_A = {sel[4], prg_inner};
  end else begin : g_no_outer
    assign PRG_A = prg_inner;
  end

  assign nPRG_CE  = nCPU_ROMSEL | !nCPU_RW;
  assign nWRAM_CE = !(nCPU_ROMSEL && CPU_A14 && CPU_A13 && !prg[4]);

  // Registers keep all five bits even when narrower outputs ignore some.
  assign unused_bits = ^{chr0, chr1, prg, sel};

endmodule

// File: tb/tb_mmc1_serial_mapper.sv
module tb_mmc1_serial_mapper;

  logic m2 = 1'b0, rst = 1'b0;
  logic romsel_n = 1'b1, rw_n = 1'b1, a13 = 1'b0, a14 = 1'b0, d0 = 1'b0, d7 = 1'b0;
  logic p10 = 1'b0, p11 = 1'b0, p12 = 1'b0;

  logic       ciram0, nprg0, nwram0;
  logic [4:0] prga0, chra0;
  logic [2:0] cnt0;
  logic       ciram1, nprg1, nwram1;
  logic [1:0] prga1;
  logic [2:0] chra1, cnt1;

  int n_tests = 0, n_fail = 0;

  // dut0: SUROM-style board with write filtering
  mmc1_serial_mapper #(.PRG_BANK_W(4), .CHR_BANK_W(5), .OUTER_PRG(1), .WR_FILTER(1)) dut0 (
    .CPU_M2(m2), .RST(rst), .nCPU_ROMSEL(romsel_n), .nCPU_RW(rw_n),
    .CPU_A13(a13), .CPU_A14(a14), .CPU_D0(d0), .CPU_D7(d7),
    .PPU_A10(p10), .PPU_A11(p11), .PPU_A12(p12),
    .CIRAM_A10(ciram0), .PRG_A(prga0), .CHR_A(chra0),
    .nPRG_CE(nprg0), .nWRAM_CE(nwram0), .SHIFT_CNT(cnt0));

  // dut1: narrow banks, no filter, no outer bit
  mmc1_serial_mapper #(.PRG_BANK_W(2), .CHR_BANK_W(3), .OUTER_PRG(0), .WR_FILTER(0)) dut1 (
    .CPU_M2(m2), .RST(rst), .nCPU_ROMSEL(romsel_n), .nCPU_RW(rw_n),
    .CPU_A13(a13), .CPU_A14(a14), .CPU_D0(d0), .CPU_D7(d7),
    .PPU_A10(p10), .PPU_A11(p11), .PPU_A12(p12),
    .CIRAM_A10(ciram1), .PRG_A(prga1), .CHR_A(chra1),
    .nPRG_CE(nprg1), .nWRAM_CE(nwram1), .SHIFT_CNT(cnt1));

  always #50 m2 = ~m2;

  // ---------------- reference model (index 0 = dut0, 1 = dut1) ----------------
  int m_ctrl[2], m_chr0[2], m_chr1[2], m_prg[2];
  int m_pn[2], m_pv[2];   // number of pending serial bits and their value
  bit m_pw[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ctrl[k] = 12; m_chr0[k] = 0; m_chr1[k] = 0; m_prg[k] = 0;
      m_pn[k] = 0; m_pv[k] = 0; m_pw[k] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit romw = !romsel_n && !rw_n;
    int v;
    for (int k = 0; k < 2; k++) begin
      if (romw && !(k == 0 && m_pw[k])) begin
        if (d7) begin
          m_pn[k] = 0; m_pv[k] = 0; m_ctrl[k] = m_ctrl[k] | 12;
        end else if (m_pn[k] < 4) begin
          m_pv[k] = m_pv[k] + (int'(d0) << m_pn[k]); m_pn[k]++;
        end else begin
          v = m_pv[k] + (int'(d0) << 4);
          case (int'(a14) * 2 + int'(a13))
            0: m_ctrl[k] = v;
            1: m_chr0[k] = v;
            2: m_chr1[k] = v;
            default: m_prg[k] = v;
          endcase
          m_pn[k] = 0; m_pv[k] = 0;
        end
      end
      m_pw[k] = romw;
    end
  endfunction

  function automatic int e_sel(int k, bit pa12);
    return (((m_ctrl[k] >> 4) & 1) == 1 && pa12) ? m_chr1[k] : m_chr0[k];
  endfunction

  function automatic int e_ciram(int k, bit pa10, bit pa11);
    case (m_ctrl[k] & 3)
      0: return 0;
      1: return 1;
      2: return int'(pa10);
      default: return int'(pa11);
    endcase
  endfunction

  function automatic int e_chr(int k, bit pa12);
    int m = 1 << ((k == 0) ? 5 : 3);
    if (((m_ctrl[k] >> 4) & 1) == 1) return e_sel(k, pa12) % m;
    return (m_chr0[k] % m) / 2 * 2 + int'(pa12);
  endfunction

  function automatic int e_prg(int k, bit b14, bit pa12);
    int pw = (k == 0) ? 4 : 2;
    int m = 1 << pw;
    int p = m_prg[k] % m;
    int r;
    case ((m_ctrl[k] >> 2) & 3)
      2: r = b14 ? p : 0;
      3: r = b14 ? m - 1 : p;
      default: r = p / 2 * 2 + int'(b14);
    endcase
    if (k == 0) r = r + (((e_sel(k, pa12) >> 4) & 1) << pw);
    return r;
  endfunction

  function automatic bit e_wram(int k);
    return !(romsel_n && a14 && a13 && m_prg[k] < 16);
  endfunction

  // ---------------- stimulus ----------------
  task automatic bus(input bit rs, input bit rw, input bit b14, input bit b13,
                     input bit bd0, input bit bd7);
    @(posedge m2); #1;
    romsel_n = rs; rw_n = rw; a14 = b14; a13 = b13; d0 = bd0; d7 = bd7;
    @(negedge m2);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input bit b14, input bit b13, input bit bd0, input bit bd7);
    bus(1'b0, 1'b0, b14, b13, bd0, bd7);
  endtask

  // Five spaced writes, bit 0 first.
  task automatic ser(input bit b14, input bit b13, input logic [4:0] v);
    for (int i = 0; i < 5; i++) begin
      idle();
      wr(b14, b13, v[i], 1'b0);
    end
  endtask

  // Live-input probe in the M2 low phase (no edge is reached).
  task automatic set_in(input bit rs, input bit rw, input bit b14, input bit b13,
                        input bit pa10, input bit pa11, input bit pa12);
    romsel_n = rs; rw_n = rw; a14 = b14; a13 = b13; p10 = pa10; p11 = pa11; p12 = pa12;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #10 rst = 1'b1; #1; model_reset();
    set_in(1, 1, 0, 0, 0, 0, 0);
    n_tests++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0h want 0", cnt0); end
    n_tests++; if (ciram0 !== 1'b0) begin n_fail++; $display("FAIL reset_ciram got %0h want 0", ciram0); end
    n_tests++; if (prga0 !== 5'h00) begin n_fail++; $display("FAIL reset_prg_lo got %0h want 0", prga0); end
    n_tests++; if (chra0 !== 5'h00) begin n_fail++; $display("FAIL reset_chr_lo got %0h want 0", chra0); end
    n_tests++; if (nwram0 !== 1'b1) begin n_fail++; $display("FAIL reset_wram_a14lo got %0h want 1", nwram0); end
    set_in(1, 1, 1, 1, 1, 1, 1);
    n_tests++; if (ciram0 !== 1'b0) begin n_fail++; $display("FAIL reset_ciram_hi got %0h want 0", ciram0); end
    n_tests++; if (prga0 !== 5'h0F) begin n_fail++; $display("FAIL reset_prg_hi got %0h want f", prga0); end
    n_tests++; if (chra0 !== 5'h01) begin n_fail++; $display("FAIL reset_chr_hi got %0h want 1", chra0); end
    n_tests++; if (nwram0 !== 1'b0) begin n_fail++; $display("FAIL reset_wram got %0h want 0", nwram0); end
    n_tests++; if (prga1 !== 2'b11) begin n_fail++; $display("FAIL reset_prg_narrow got %0h want 3", prga1); end
    n_tests++; if (chra1 !== 3'b001) begin n_fail++; $display("FAIL reset_chr_narrow got %0h want 1", chra1); end
    #5 rst = 1'b0;
  endtask

  task automatic test_ctrl_serial();
    logic [4:0] bits = 5'b01110;
    for (int i = 0; i < 5; i++) begin
      idle();
      wr(0, 0, bits[i], 0);
      n_tests++;
      if (cnt0 !== 3'((i + 1) % 5)) begin
        n_fail++; $display("FAIL serial_cnt[%0d] got %0d want %0d", i, cnt0, (i + 1) % 5);
      end
    end
    set_in(1, 1, 0, 0, 0, 1, 0);
    n_tests++; if (ciram0 !== 1'b0) begin n_fail++; $display("FAIL mirror_a10_lo got %0h want 0", ciram0); end
    set_in(1, 1, 0, 0, 1, 0, 0);
    n_tests++; if (ciram0 !== 1'b1) begin n_fail++; $display("FAIL mirror_a10_hi got %0h want 1", ciram0); end
  endtask

  task automatic test_prg_modes();
    ser(1, 1, 5'd5);
    set_in(1, 1, 0, 0, 0, 0, 0);
    n_tests++; if (prga0 !== 5'h05) begin n_fail++; $display("FAIL prg_m3_lo got %0h want 5", prga0); end
    set_in(1, 1, 1, 0, 0, 0, 0);
    n_tests++; if (prga0 !== 5'h0F) begin n_fail++; $display("FAIL prg_m3_hi got %0h want f", prga0); end
    ser(0, 0, 5'b00010);
    ser(1, 1, 5'd6);
    set_in(1, 1, 0, 0, 0, 0, 0);
    n_tests++; if (prga0 !== 5'h06) begin n_fail++; $display("FAIL prg_m0_lo got %0h want 6", prga0); end
    set_in(1, 1, 1, 0, 0, 0, 0);
    n_tests++; if (prga0 !== 5'h07) begin n_fail++; $display("FAIL prg_m0_hi got %0h want 7", prga0); end
    ser(0, 0, 5'b01010);
    set_in(1, 1, 0, 0, 0, 0, 0);
    n_tests++; if (prga0 !== 5'h00) begin n_fail++; $display("FAIL prg_m2_lo got %0h want 0", prga0); end
    set_in(1, 1, 1, 0, 0, 0, 0);
    n_tests++; if (prga0 !== 5'h06) begin n_fail++; $display("FAIL prg_m2_hi got %0h want 6", prga0); end
  endtask

  task automatic test_back_to_back();
    idle(); wr(0, 0, 1, 0); wr(0, 0, 0, 0);
    n_tests++; if (cnt0 !== 3'd1) begin n_fail++; $display("FAIL rmw_cnt got %0d want 1", cnt0); end
    idle(); wr(0, 0, 0, 0);
    n_tests++; if (cnt0 !== 3'd2) begin n_fail++; $display("FAIL gap_cnt got %0d want 2", cnt0); end
    idle(); wr(0, 0, 1, 0); idle(); wr(0, 0, 0, 0); idle(); wr(0, 1, 0, 0);
    n_tests++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL rmw_commit_cnt got %0d want 0", cnt0); end
    // accepted bits 1,0,1,0,0 -> chr0 = 5
    set_in(1, 1, 0, 0, 0, 0, 0);
    n_tests++; if (chra0 !== 5'h04) begin n_fail++; $display("FAIL rmw_chr_lo got %0h want 4", chra0); end
    set_in(1, 1, 0, 0, 0, 0, 1);
    n_tests++; if (chra0 !== 5'h05) begin n_fail++; $display("FAIL rmw_chr_hi got %0h want 5", chra0); end
  endtask

  task automatic test_d7_reset();
    ser(0, 0, 5'b10001);
    set_in(1, 1, 1, 0, 0, 0, 0);
    n_tests++; if (prga0 !== 5'h07) begin n_fail++; $display("FAIL d7_pre_prg got %0h want 7", prga0); end
    idle(); wr(0, 0, 1, 0); idle(); wr(0, 0, 0, 0); idle(); wr(0, 0, 1, 0);
    n_tests++; if (cnt0 !== 3'd3) begin n_fail++; $display("FAIL d7_pre_cnt got %0d want 3", cnt0); end
    idle(); wr(1, 1, 0, 1);
    n_tests++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL d7_cnt got %0d want 0", cnt0); end
    set_in(1, 1, 1, 0, 0, 0, 0);
    n_tests++; if (ciram0 !== 1'b1) begin n_fail++; $display("FAIL d7_mirror got %0h want 1", ciram0); end
    n_tests++; if (prga0 !== 5'h0F) begin n_fail++; $display("FAIL d7_prg_hi got %0h want f", prga0); end
    n_tests++; if (chra0 !== 5'h05) begin n_fail++; $display("FAIL d7_chr0 got %0h want 5", chra0); end
    set_in(1, 1, 0, 0, 0, 0, 1);
    n_tests++; if (prga0 !== 5'h06) begin n_fail++; $display("FAIL d7_prg_lo got %0h want 6", prga0); end
    n_tests++; if (chra0 !== 5'h00) begin n_fail++; $display("FAIL d7_chr1 got %0h want 0", chra0); end
    // D7 in place of the 5th write: nothing is committed
    for (int i = 0; i < 4; i++) begin idle(); wr(1, 1, 1, 0); end
    n_tests++; if (cnt0 !== 3'd4) begin n_fail++; $display("FAIL d7_fifth_pre got %0d want 4", cnt0); end
    idle(); wr(1, 1, 1, 1);
    set_in(1, 1, 0, 0, 0, 0, 0);
    n_tests++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL d7_fifth_cnt got %0d want 0", cnt0); end
    n_tests++; if (prga0 !== 5'h06) begin n_fail++; $display("FAIL d7_fifth_prg got %0h want 6", prga0); end
  endtask

  task automatic test_chr_outer();
    ser(0, 1, 5'h03);
    ser(1, 0, 5'h1A);
    set_in(1, 1, 0, 0, 0, 0, 0);
    n_tests++; if (chra0 !== 5'h03) begin n_fail++; $display("FAIL chr4k_lo got %0h want 3", chra0); end
    n_tests++; if (prga0 !== 5'h06) begin n_fail++; $display("FAIL outer_lo got %0h want 6", prga0); end
    set_in(1, 1, 0, 0, 0, 0, 1);
    n_tests++; if (chra0 !== 5'h1A) begin n_fail++; $display("FAIL chr4k_hi got %0h want 1a", chra0); end
    n_tests++; if (prga0 !== 5'h16) begin n_fail++; $display("FAIL outer_hi got %0h want 16", prga0); end
    set_in(1, 1, 1, 0, 0, 0, 1);
    n_tests++; if (prga0 !== 5'h1F) begin n_fail++; $display("FAIL outer_fixed got %0h want 1f", prga0); end
  endtask

  task automatic test_wram();
    ser(1, 1, 5'b10000);
    set_in(1, 1, 1, 1, 0, 0, 0);
    n_tests++; if (nwram0 !== 1'b1) begin n_fail++; $display("FAIL wram_disabled got %0h want 1", nwram0); end
    ser(1, 1, 5'b00000);
    set_in(1, 1, 1, 1, 0, 0, 0);
    n_tests++; if (nwram0 !== 1'b0) begin n_fail++; $display("FAIL wram_enabled got %0h want 0", nwram0); end
    set_in(1, 1, 0, 1, 0, 0, 0);
    n_tests++; if (nwram0 !== 1'b1) begin n_fail++; $display("FAIL wram_a14lo got %0h want 1", nwram0); end
    set_in(0, 1, 0, 0, 0, 0, 0);
    n_tests++; if (nprg0 !== 1'b0) begin n_fail++; $display("FAIL prgce_read got %0h want 0", nprg0); end
    set_in(0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (nprg0 !== 1'b1) begin n_fail++; $display("FAIL prgce_write got %0h want 1", nprg0); end
    set_in(1, 1, 0, 0, 0, 0, 0);
    n_tests++; if (nprg0 !== 1'b1) begin n_fail++; $display("FAIL prgce_idle got %0h want 1", nprg0); end
  endtask

  task automatic test_reset_mid();
    idle(); wr(0, 0, 1, 0); idle(); wr(0, 0, 1, 0);
    n_tests++; if (cnt0 !== 3'd2) begin n_fail++; $display("FAIL mid_pre_cnt got %0d want 2", cnt0); end
    #5 rst = 1'b1; #1; model_reset();
    set_in(1, 1, 1, 0, 1, 1, 1);
    n_tests++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL mid_cnt got %0d want 0", cnt0); end
    n_tests++; if (ciram0 !== 1'b0) begin n_fail++; $display("FAIL mid_mirror got %0h want 0", ciram0); end
    n_tests++; if (prga0 !== 5'h0F) begin n_fail++; $display("FAIL mid_prg_hi got %0h want f", prga0); end
    n_tests++; if (chra0 !== 5'h01) begin n_fail++; $display("FAIL mid_chr got %0h want 1", chra0); end
    set_in(1, 1, 0, 0, 1, 1, 1);
    n_tests++; if (prga0 !== 5'h00) begin n_fail++; $display("FAIL mid_prg_lo got %0h want 0", prga0); end
    #2 rst = 1'b0;
    idle(); wr(0, 0, 1, 0);
    n_tests++; if (cnt0 !== 3'd1) begin n_fail++; $display("FAIL mid_restart got %0d want 1", cnt0); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      p10 = 1'($urandom % 2); p11 = 1'($urandom % 2); p12 = 1'($urandom % 2);
      bus(($urandom % 3) == 0, ($urandom % 4) == 0, 1'($urandom % 2), 1'($urandom % 2),
          1'($urandom % 2), ($urandom % 16) == 0);
      if (($urandom % 100) == 0) begin rst = 1'b1; #1; model_reset(); rst = 1'b0; #1; end
      n_tests++; if (cnt0 !== 3'(m_pn[0])) begin n_fail++; $display("FAIL rnd_cnt0 it%0d got %0d want %0d", it, cnt0, m_pn[0]); end
      n_tests++; if (cnt1 !== 3'(m_pn[1])) begin n_fail++; $display("FAIL rnd_cnt1 it%0d got %0d want %0d", it, cnt1, m_pn[1]); end
      n_tests++; if (ciram0 !== 1'(e_ciram(0, p10, p11))) begin n_fail++; $display("FAIL rnd_ciram0 it%0d got %0h want %0h", it, ciram0, e_ciram(0, p10, p11)); end
      n_tests++; if (ciram1 !== 1'(e_ciram(1, p10, p11))) begin n_fail++; $display("FAIL rnd_ciram1 it%0d got %0h want %0h", it, ciram1, e_ciram(1, p10, p11)); end
      n_tests++; if (chra0 !== 5'(e_chr(0, p12))) begin n_fail++; $display("FAIL rnd_chr0 it%0d got %0h want %0h", it, chra0, e_chr(0, p12)); end
      n_tests++; if (chra1 !== 3'(e_chr(1, p12))) begin n_fail++; $display("FAIL rnd_chr1 it%0d got %0h want %0h", it, chra1, e_chr(1, p12)); end
      n_tests++; if (prga0 !== 5'(e_prg(0, a14, p12))) begin n_fail++; $display("FAIL rnd_prg0 it%0d got %0h want %0h", it, prga0, e_prg(0, a14, p12)); end
      n_tests++; if (prga1 !== 2'(e_prg(1, a14, p12))) begin n_fail++; $display("FAIL rnd_prg1 it%0d got %0h want %0h", it, prga1, e_prg(1, a14, p12)); end
      n_tests++; if (nwram0 !== e_wram(0)) begin n_fail++; $display("FAIL rnd_wram0 it%0d got %0h want %0h", it, nwram0, e_wram(0)); end
      n_tests++; if (nwram1 !== e_wram(1)) begin n_fail++; $display("FAIL rnd_wram1 it%0d got %0h want %0h", it, nwram1, e_wram(1)); end
      n_tests++; if (nprg1 !== (romsel_n | !rw_n)) begin n_fail++; $display("FAIL rnd_prgce it%0d got %0h want %0h", it, nprg1, romsel_n | !rw_n); end
    end
  endtask

  initial begin
    test_reset();
    test_ctrl_serial();
    test_prg_modes();
    test_back_to_back();
    test_d7_reset();
    test_chr_outer();
    test_wram();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmc1_serial_mapper.md
# mmc1_serial_mapper

Parametrised MMC1-class PRG/CHR/mirroring bank controller sitting between the CPU/PPU cartridge edge and the PRG ROM, CHR ROM/RAM, WRAM and CIRAM. Software programs it through a 5-write serial port at $8000-$FFFF. This generation adds:

- configurable bank widths
- an optional SUROM-style outer PRG bit
- consecutive-write filtering
- a WRAM-disable bit
- fully combinational (glitch-free w.r.t. PPU) address outputs

## Interface

Parameters:

- PRG_BANK_W, 4, inner PRG bank bits (1..4), 16 KB units
- CHR_BANK_W, 5, CHR bank bits (1..5), 4 KB units
- OUTER_PRG, 0, 1 = selected CHR register bit 4 drives extra PRG MSB (512 KB boards)
- WR_FILTER, 1, 1 = ignore ROM-space write on M2 cycle immediately after an accepted-or-ignored ROM write

Ports (one clock; reset is asynchronous and active-high):

- CPU_M2  in  1  clock; all state updates on falling edge
- RST  in  1  asynchronous, active-high reset
- nCPU_ROMSEL  in  1  low = $8000-$FFFF access
- nCPU_RW  in  1  low = write
- CPU_A13, CPU_A14  in  1 each  register select / PRG half select
- CPU_D0, CPU_D7  in  1 each  serial data / shift reset
- PPU_A10, PPU_A11, PPU_A12  in  1 each  PPU address bits
- CIRAM_A10  out  1  nametable select
- PRG_A  out  PRG_BANK_W+OUTER_PRG  PRG A14 and up
- CHR_A  out  CHR_BANK_W  CHR A12 and up
- nPRG_CE  out  1  = nCPU_ROMSEL | !nCPU_RW
- nWRAM_CE  out  1  low only when nCPU_ROMSEL=1, A14=1, A13=1, WRAM enabled
- SHIFT_CNT  out  3  accepted bits pending (0..4), debug/verification

## Operation

- State:
  - ctrl[4:0], reset value 5'b01100
  - chr0, chr1, reset value 0
  - prg[4:0], reset value 0; prg[4]=1 disables WRAM
  - shift[3:0]
  - cnt (0..4)
  - prev_wr
- ROM write = !nCPU_ROMSEL & !nCPU_RW at the falling edge.
- prev_wr <= ROM write on every falling edge.
- A ROM write is ignored when WR_FILTER=1 and prev_wr=1. An ignored write changes nothing except prev_wr.
- Accepted write, D7=1:
  - cnt <= 0, shift <= 0
  - ctrl[3:2] <= 2'b11; other ctrl bits unchanged (bitwise OR)
- Accepted write, D7=0, cnt<4: shift[cnt] <= D0, cnt <= cnt+1.
- Accepted write, D7=0, cnt=4: value = {D0, shift[3:0]} (first write = bit 0). It is committed to the register selected by {A14,A13}:
  - 00 → ctrl
  - 01 → chr0
  - 10 → chr1
  - 11 → prg
  - Then cnt <= 0.
- Registers store all 5 bits; outputs use the low bits as stated below.
- Mirroring, ctrl[1:0]:
  - 00 → CIRAM_A10 = 0
  - 01 → CIRAM_A10 = 1
  - 10 → CIRAM_A10 = PPU_A10
  - 11 → CIRAM_A10 = PPU_A11
- CHR: sel = ctrl[4] ? (PPU_A12 ? chr1 : chr0) : chr0.
  - ctrl[4]=1: CHR_A = sel[CHR_BANK_W-1:0].
  - ctrl[4]=0: CHR_A = {chr0[CHR_BANK_W-1:1], PPU_A12}.
- PRG inner bits, by ctrl[3:2]:
  - 0x → {prg[W-1:1], CPU_A14}
  - 10 → A14 ? prg : 0
  - 11 → A14 ? all-ones : prg
- OUTER_PRG=1: PRG_A MSB = sel[4], independent of mode.

## Timing

- State changes only on the CPU_M2 falling edge or RST assertion.
- Register commit takes effect on outputs immediately after the 5th accepted write's falling edge; 0 cycles of extra latency.
- CIRAM_A10, CHR_A, PRG_A, nPRG_CE, nWRAM_CE are purely combinational from state and live inputs. No PPU signal is sampled by CPU_M2.
- RST asserted at any time, including mid-sequence: all state returns to its reset value asynchronously.
  - Outputs immediately: mirroring 0, PRG mode 3 (PRG_A = all-ones for A14=1, 0 for A14=0), CHR_A = {0, PPU_A12}, SHIFT_CNT = 0.
- Back-to-back ROM writes (RMW): with WR_FILTER=1, only the first is accepted. A write two cycles later is accepted.
- D7 reset on the 5th write: no commit occurs.

## Test plan

- Reset, then write D0 sequence 0,1,1,1,0 to $8000 on non-consecutive cycles → ctrl=5'b01110; CIRAM_A10 tracks PPU_A10; SHIFT_CNT returns to 0.
- After the above, write 5 → $E000 → PRG_A=4'h5 at A14=0, 4'hF at A14=1. Then ctrl mode 0 with prg=6 → PRG_A = {3'b011, A14}.
- WR_FILTER=1: write D0=1 then D0=0 on consecutive M2 cycles → SHIFT_CNT=1, shift[0]=1. Repeat with one idle cycle between → SHIFT_CNT=2.
- Three writes, then a D7=1 write with ctrl=5'b10001 → SHIFT_CNT=0, ctrl=5'b11101, chr registers unchanged.
- ctrl[4]=1, chr0=5'h03, chr1=5'h1A → CHR_A=3 for PPU_A12=0, 5'h1A for PPU_A12=1. With OUTER_PRG=1, PRG_A MSB follows PPU_A12 (0 then 1).
- prg=5'b10000 → nWRAM_CE stays 1 at $6000 reads. prg=0 → nWRAM_CE=0. RST mid-sequence (after 2 writes) → SHIFT_CNT=0, ctrl=5'b01100.
